baud_cfg_ctrl: RTL and testbench

BAUD_CFG_CTRL -- requirements
Module: baud_cfg_ctrl

---
 rtl/baud_cfg_ctrl.sv | 132 +++++++++++++
 tb/tb_baud_cfg_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_cfg_ctrl.sv
// Baud-rate configuration controller: free-running tick generator plus an FSM that
// waits for the link to go quiet, switches the rate, and then suppresses ticks briefly.
module baud_cfg_ctrl #(
    parameter int unsigned TIMEOUT_W  = 16,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    input  logic [1:0] cfg_rate,
    output logic       cfg_ready,
    input  logic       tx_busy,
    input  logic       rx_busy,
    output logic [1:0] bd_rate,
    output logic       tx_tick,
    output logic       rx_tick,
    output logic       cfg_done,
    output logic       cfg_err
);

    // state      | meaning
    // IDLE       | ready for a request, ticks running
    // WAIT_QUIET | request pending, waiting for both directions to be idle
    // SETTLE     | new rate applied, ticks held off for SETTLE_CYC cycles
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_QUIET = 2'd1,
        SETTLE     = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WAIT_MAX    = '1;
    localparam logic [TIMEOUT_W-1:0] WAIT_ONE    = TIMEOUT_W'(1);
    localparam logic [3:0]           SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t               state_q, state_d;
    logic [9:0]           cnt_q, cnt_d;
    logic [1:0]           bd_rate_q, bd_rate_d;
    logic [1:0]           pending_q, pending_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic [3:0]           settle_q, settle_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 run_q, run_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 10'd1;
        bd_rate_d = bd_rate_q;
        pending_d = pending_q;
        wait_d    = wait_q;
        settle_d  = settle_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        run_d     = 1'b1;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    pending_d = cfg_rate;
                    if (cfg_rate == bd_rate_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = WAIT_QUIET;
                        wait_d  = '0;
                    end
                end
            end
            WAIT_QUIET: begin
                // Going quiet takes priority over a timeout landing in the same cycle.
                if (!tx_busy && !rx_busy) begin
                    bd_rate_d = pending_q;
                    cnt_d     = '0;
                    settle_d  = SETTLE_LOAD;
                    state_d   = SETTLE;
                end else if (wait_q == WAIT_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            SETTLE: begin
                if (settle_q == 4'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bd_rate_q <= 2'b00;
            pending_q <= 2'b00;
            wait_q    <= '0;
            settle_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bd_rate_q <= bd_rate_d;
            pending_q <= pending_d;
            wait_q    <= wait_d;
            settle_q  <= settle_d;
            done_q    <= done_d;
            err_q     <= err_d;
            run_q     <= run_d;
        end
    end

    // run_q masks the cnt==0 cycle right after reset release only; later wraps tick normally.
    logic [9:0] tx_mask, rx_mask;
    logic       ticks_on;

    assign tx_mask  = (10'd1 << (4'd7 + 4'(bd_rate_q))) - 10'd1;
    assign rx_mask  = (10'd1 << (4'd3 + 4'(bd_rate_q))) - 10'd1;
    assign ticks_on = run_q && (state_q != SETTLE);

    assign tx_tick   = ticks_on && ((cnt_q & tx_mask) == 10'd0);
    assign rx_tick   = ticks_on && ((cnt_q & rx_mask) == 10'd0);
    assign cfg_ready = (state_q == IDLE);
    assign bd_rate   = bd_rate_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Bench for baud_cfg_ctrl: two instances (default and short timeout) checked every
// cycle against a behavioural model, plus directed vector table and corner sequences.
module tb_baud_cfg_ctrl;

    localparam int SC = 4;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic [1:0] cfg_rate;
    logic       tx_busy;
    logic       rx_busy;

    logic       rdy  [2];
    logic [1:0] rate [2];
    logic       txt  [2];
    logic       rxt  [2];
    logic       done [2];
    logic       err  [2];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    baud_cfg_ctrl dut0 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_rate(cfg_rate),
        .cfg_ready(rdy[0]), .tx_busy(tx_busy), .rx_busy(rx_busy), .bd_rate(rate[0]),
        .tx_tick(txt[0]), .rx_tick(rxt[0]), .cfg_done(done[0]), .cfg_err(err[0])
    );

    baud_cfg_ctrl #(.TIMEOUT_W(4), .SETTLE_CYC(SC)) dut1 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_rate(cfg_rate),
        .cfg_ready(rdy[1]), .tx_busy(tx_busy), .rx_busy(rx_busy), .bd_rate(rate[1]),
        .tx_tick(txt[1]), .rx_tick(rxt[1]), .cfg_done(done[1]), .cfg_err(err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: mode 0 idle, 1 waiting for quiet, 2 settling.
    typedef struct {
        int mode;
        int rate;
        int pend;
        int cnt;
        int waited;
        int settle_left;
        bit done;
        bit err;
        bit started;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mreset();
        mdl_t m;
        m.mode = 0; m.rate = 0; m.pend = 0; m.cnt = 0; m.waited = 0;
        m.settle_left = 0; m.done = 0; m.err = 0; m.started = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit v, int r, bit txb, bit rxb, int tmax);
        mdl_t n = m;
        n.done = 0;
        n.err = 0;
        n.started = 1;
        n.cnt = (m.cnt + 1) % 1024;
        if (m.mode == 0) begin
            if (v) begin
                n.pend = r;
                if (r == m.rate) n.done = 1;
                else begin n.mode = 1; n.waited = 0; end
            end
        end else if (m.mode == 1) begin
            if (!txb && !rxb) begin
                n.rate = m.pend; n.cnt = 0; n.mode = 2; n.settle_left = SC;
            end else if (m.waited == tmax) begin
                n.err = 1; n.mode = 0;
            end else n.waited = m.waited + 1;
        end else begin
            n.settle_left = m.settle_left - 1;
            if (n.settle_left == 0) begin n.mode = 0; n.done = 1; end
        end
        return n;
    endfunction

    function automatic bit mtx(mdl_t m);
        return m.started && m.mode != 2 && (m.cnt % (1 << (7 + m.rate))) == 0;
    endfunction

    function automatic bit mrx(mdl_t m);
        return m.started && m.mode != 2 && (m.cnt % (1 << (3 + m.rate))) == 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 = mreset();
            m1 = mreset();
        end else begin
            m0 = mstep(m0, cfg_valid, int'(cfg_rate), tx_busy, rx_busy, 65535);
            m1 = mstep(m1, cfg_valid, int'(cfg_rate), tx_busy, rx_busy, 15);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("d0_ready", 32'(rdy[0]),  32'(m0.mode == 0));
            chk("d0_rate",  32'(rate[0]), 32'(m0.rate));
            chk("d0_tx",    32'(txt[0]),  32'(mtx(m0)));
            chk("d0_rx",    32'(rxt[0]),  32'(mrx(m0)));
            chk("d0_done",  32'(done[0]), 32'(m0.done));
            chk("d0_err",   32'(err[0]),  32'(m0.err));
            chk("d1_ready", 32'(rdy[1]),  32'(m1.mode == 0));
            chk("d1_rate",  32'(rate[1]), 32'(m1.rate));
            chk("d1_tx",    32'(txt[1]),  32'(mtx(m1)));
            chk("d1_rx",    32'(rxt[1]),  32'(mrx(m1)));
            chk("d1_done",  32'(done[1]), 32'(m1.done));
            chk("d1_err",   32'(err[1]),  32'(m1.err));
        end
    end

    typedef struct {
        bit       v;
        bit [1:0] r;
        bit       txb;
        bit       rxb;
        int       n;
        bit [1:0] e_rate;
        bit       e_ready;
        bit       e_done;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int first_rx;
        int waited;
        int busy_pct;

        tbl[0]  = '{1, 0, 0, 0, 1,   0, 1, 1};
        tbl[1]  = '{0, 0, 0, 0, 1,   0, 1, 0};
        tbl[2]  = '{1, 1, 1, 0, 1,   0, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 150, 0, 0, 0};
        tbl[4]  = '{1, 3, 1, 0, 1,   0, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 148, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 1,   1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 3,   1, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 1,   1, 1, 1};
        tbl[9]  = '{0, 0, 0, 0, 1,   1, 1, 0};
        tbl[10] = '{1, 3, 0, 0, 1,   1, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 1,   3, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 3,   3, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 1,   3, 1, 1};
        tbl[14] = '{0, 0, 0, 0, 1,   3, 1, 0};
        tbl[15] = '{1, 3, 0, 0, 1,   3, 1, 1};
        tbl[16] = '{0, 0, 0, 0, 1,   3, 1, 0};

        rst = 1'b0; cfg_valid = 1'b0; cfg_rate = 2'd0; tx_busy = 1'b0; rx_busy = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_rate",  32'(rate[0]), 32'd0);
        chk("rst_tx",    32'(txt[0]), 32'd0);
        chk("rst_rx",    32'(rxt[0]), 32'd0);
        chk("rst_done",  32'(done[0]), 32'd0);
        chk("rst_err",   32'(err[0]), 32'd0);
        chk_en = 1;

        // Default rate after release: rx every 8, tx every 128, nothing at cnt 0.
        @(negedge clk);
        rst = 1'b0;
        first_rx = -1;
        for (int k = 0; k < 2048; k++) begin
            #1;
            if (first_rx < 0 && rxt[0]) first_rx = k;
            chk("def_rx", 32'(rxt[0]), 32'(k > 0 && k % 8 == 0));
            chk("def_tx", 32'(txt[0]), 32'(k > 0 && k % 128 == 0));
            @(negedge clk);
        end
        chk("first_rx", 32'(first_rx), 32'd8);

        for (int i = 0; i < 17; i++) begin
            cfg_valid = tbl[i].v; cfg_rate = tbl[i].r;
            tx_busy = tbl[i].txb; rx_busy = tbl[i].rxb;
            repeat (tbl[i].n) @(negedge clk);
            #1;
            chk($sformatf("vec%0d_rate", i),  32'(rate[0]), 32'(tbl[i].e_rate));
            chk($sformatf("vec%0d_ready", i), 32'(rdy[0]),  32'(tbl[i].e_ready));
            chk($sformatf("vec%0d_done", i),  32'(done[0]), 32'(tbl[i].e_done));
        end
        cfg_valid = 1'b0;

        // Reset in the middle of SETTLE: request is discarded, ticks restart at rate 0.
        @(negedge clk);
        cfg_valid = 1'b1; cfg_rate = 2'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_rate",  32'(rate[0]), 32'd0);
        chk("mid_rst_ready", 32'(rdy[0]), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 64; k++) begin
            #1;
            chk("post_rst_rx",   32'(rxt[0]), 32'(k > 0 && k % 8 == 0));
            chk("post_rst_done", 32'(done[0]), 32'd0);
            @(negedge clk);
        end

        // Timeout on the short-timeout instance with rx_busy stuck high.
        rx_busy = 1'b1; cfg_valid = 1'b1; cfg_rate = 2'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        waited = 0;
        while (!err[1] && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("to_cycles", 32'(waited), 32'd16);
        chk("to_rate",   32'(rate[1]), 32'd0);
        chk("to_ready",  32'(rdy[1]), 32'd1);
        chk("to_d0_wait", 32'(rdy[0]), 32'd0);
        rx_busy = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("to_d0_rate", 32'(rate[0]), 32'd1);

        // Busy drops in the very cycle the wait counter is at its limit: switch wins.
        rx_busy = 1'b1; cfg_valid = 1'b1; cfg_rate = 2'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (15) @(negedge clk);
        rx_busy = 1'b0;
        @(negedge clk);
        #1;
        chk("tie_err",  32'(err[1]), 32'd0);
        chk("tie_rate", 32'(rate[1]), 32'd2);
        chk("tie_d0_rate", 32'(rate[0]), 32'd2);
        repeat (8) @(negedge clk);

        // Randomized traffic with bursty busy and occasional resets.
        busy_pct = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0: busy_pct = 0;
                    1: busy_pct = 50;
                    2: busy_pct = 97;
                    default: busy_pct = 100;
                endcase
            end
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_rate  = 2'($urandom_range(0, 3));
            tx_busy   = ($urandom_range(0, 99) < busy_pct);
            rx_busy   = ($urandom_range(0, 99) < busy_pct / 2);
            rst       = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0; cfg_valid = 1'b0; tx_busy = 1'b0; rx_busy = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
